apb_gpio_irq: RTL

//  Parametrised APB GPIO port, successor to the fixed 16-bit APB2GPIO: per-pin direction, output data,

---
 rtl/gpio_pkg.sv | 25 ++
 rtl/gpio_sync_edge.sv | 46 ++++
 rtl/apb_gpio_irq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map constants for the APB GPIO port
// Purpose: register byte offsets (PADDR[11:0] with the two low bits forced to 0),
//          the largest supported pin count and the offset decode helper.
// Ports: none (package).
package gpio_pkg;

   localparam int MAX_WIDTH = 32;

   localparam logic [11:0] GPIO_MR_OFS  = 12'h000;
   localparam logic [11:0] GPIO_DR_OFS  = 12'h004;
   localparam logic [11:0] GPIO_SET_OFS = 12'h008;
   localparam logic [11:0] GPIO_CLR_OFS = 12'h00C;
   localparam logic [11:0] GPIO_IE_OFS  = 12'h010;
   localparam logic [11:0] GPIO_POL_OFS = 12'h014;
   localparam logic [11:0] GPIO_IS_OFS  = 12'h018;

   function automatic logic ofs_mapped(input logic [11:0] ofs);
      case (ofs)
         GPIO_MR_OFS, GPIO_DR_OFS, GPIO_SET_OFS, GPIO_CLR_OFS,
         GPIO_IE_OFS, GPIO_POL_OFS, GPIO_IS_OFS: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - per-pin input synchroniser with polarity-selected edge pulse
// Purpose: brings one pad into the PCLK domain through SYNC_STAGES flops, keeps the
//          previous synchronised value and flags the selected transition for one cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_pad    raw pad value
//   i_pol    edge select: 0 = rising, 1 = falling
//   o_sync   synchronised pad value
//   o_edge   one-cycle pulse on the selected transition of o_sync
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pad,
   input  logic i_pol,
   output logic o_sync,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_rise;
   logic                   w_fall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = o_sync & ~r_prev;
   assign w_fall = ~o_sync & r_prev;
   // Polarity only steers which real transition is reported; toggling it never
   // creates a pulse because sync/prev are unaffected.
   assign o_edge = i_pol ? w_fall : w_rise;

endmodule

// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - parametrised APB GPIO port with per-pin edge interrupts
// Purpose: APB register file (MR, DR, SET, CLR, IE, POL, IS), tri-state pad drivers,
//          synchronised pin readback, sticky W1C edge status and a level IRQ.
// Ports:
//   PCLK     bus/block clock            PRESETn  asynchronous active-low reset
//   PSEL     APB select                 PENABLE  APB access phase
//   PWRITE   1 = write                  PADDR    byte address, [11:2] decoded
//   PWDATA   write data                 PRDATA   read data (combinational)
//   PREADY   tied high                  PSLVERR  unmapped offset in access phase
//   GPIO     pads, driven where MR=1    IRQ      OR of the IS bits
module apb_gpio_irq
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   inout  wire  [WIDTH-1:0]  GPIO,
   output logic              IRQ
);

   logic [11:0]          w_ofs;
   logic                 w_mapped;
   logic                 w_access;
   logic                 w_wr;
   logic [WIDTH-1:0]     w_wdata;
   logic [WIDTH-1:0]     w_sync;
   logic [WIDTH-1:0]     w_edge;
   logic [WIDTH-1:0]     w_hit;
   logic [WIDTH-1:0]     w_is_clr;
   logic [MAX_WIDTH-1:0] w_rdata;
   logic                 w_unused;

   logic [WIDTH-1:0]     r_mr;
   logic [WIDTH-1:0]     r_dr;
   logic [WIDTH-1:0]     r_ie;
   logic [WIDTH-1:0]     r_pol;
   logic [WIDTH-1:0]     r_is;

   assign w_ofs    = {PADDR[11:2], 2'b00};
   assign w_mapped = ofs_mapped(w_ofs);
   assign w_access = PSEL & PENABLE;
   assign w_wr     = w_access & PWRITE & w_mapped;
   // Bits above WIDTH-1 are simply not stored, so they read back as 0.
   assign w_wdata  = PWDATA[WIDTH-1:0];
   assign w_unused = ^{PADDR[31:12], PADDR[1:0], PWDATA};

   assign PREADY   = 1'b1;
   // Gated by reset so an interrupted transfer cannot flag an error while in reset.
   assign PSLVERR  = PRESETn & w_access & ~w_mapped;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      gpio_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
         .i_clk   (PCLK),
         .i_rst_n (PRESETn),
         .i_pad   (GPIO[i]),
         .i_pol   (r_pol[i]),
         .o_sync  (w_sync[i]),
         .o_edge  (w_edge[i])
      );
      assign GPIO[i] = r_mr[i] ? r_dr[i] : 1'bz;
   end

   always_comb begin
      w_rdata = '0;
      if (PRESETn && PSEL && !PWRITE) begin
         case (w_ofs)
            GPIO_MR_OFS:  w_rdata = MAX_WIDTH'(r_mr);
            GPIO_DR_OFS:  w_rdata = MAX_WIDTH'(w_sync);
            GPIO_IE_OFS:  w_rdata = MAX_WIDTH'(r_ie);
            GPIO_POL_OFS: w_rdata = MAX_WIDTH'(r_pol);
            GPIO_IS_OFS:  w_rdata = MAX_WIDTH'(r_is);
            default:      w_rdata = '0;
         endcase
      end
   end
   assign PRDATA = w_rdata;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_mr  <= '0;
         r_dr  <= '0;
         r_ie  <= '0;
         r_pol <= '0;
      end else if (w_wr) begin
         case (w_ofs)
            GPIO_MR_OFS:  r_mr  <= w_wdata;
            GPIO_DR_OFS:  r_dr  <= w_wdata;
            GPIO_SET_OFS: r_dr  <= r_dr | w_wdata;
            GPIO_CLR_OFS: r_dr  <= r_dr & ~w_wdata;
            GPIO_IE_OFS:  r_ie  <= w_wdata;
            GPIO_POL_OFS: r_pol <= w_wdata;
            default:      ;
         endcase
      end
   end

   assign w_hit    = r_ie & w_edge;
   assign w_is_clr = (w_wr && (w_ofs == GPIO_IS_OFS)) ? w_wdata : '0;

   // OR-ing the hit in after the clear makes a coincident edge win over W1C.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_is <= '0;
      end else begin
         r_is <= (r_is & ~w_is_clr) | w_hit;
      end
   end

   assign IRQ = |r_is;

endmodule
